apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_addr_decode.sv | 22 ++
 rtl/apb_master_bridge.sv | 163 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and address field layout for the APB master bridge
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } apb_state_e;

    localparam int NUM_SLV_DEF = 4;

    // Window (upper half), must-be-zero pad, slave index and byte alignment bits of req_addr
    localparam int WIN_HI   = 31;
    localparam int WIN_LO   = 16;
    localparam int PAD_HI   = 15;
    localparam int PAD_LO   = 14;
    localparam int IDX_HI   = 13;
    localparam int IDX_LO   = 12;
    localparam int ALIGN_HI = 1;
    localparam int ALIGN_LO = 0;
    localparam int IDX_W    = IDX_HI - IDX_LO + 1;

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - request address legality check and slave index extraction
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int          NUM_SLV = NUM_SLV_DEF,
    parameter logic [15:0] BASE_HI = 16'h0001
) (
    input  logic [31:0]      addr,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    // An address is legal only inside the window, with a zero pad, word aligned and naming a real slave
    always_comb begin
        idx   = addr[IDX_HI:IDX_LO];
        legal = (addr[WIN_HI:WIN_LO] == BASE_HI)
             && (addr[PAD_HI:PAD_LO] == '0)
             && (addr[ALIGN_HI:ALIGN_LO] == '0)
             && (32'(idx) < 32'(NUM_SLV));
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding CPU request to APB master bridge with timeout
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          NUM_SLV = NUM_SLV_DEF,
    parameter logic [15:0] BASE_HI = 16'h0001,
    parameter int          TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [31:0]           PADDR,
    output logic [NUM_SLV-1:0]    PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [32*NUM_SLV-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY,
    input  logic [NUM_SLV-1:0]    PSLVERR
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    apb_state_e         state_q, state_d;
    logic [31:0]        paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic               dec_legal;
    logic [IDX_W-1:0]   dec_idx;
    logic               sel_ready;
    logic               sel_err;
    logic [31:0]        sel_rdata;

    apb_addr_decode #(
        .NUM_SLV (NUM_SLV),
        .BASE_HI (BASE_HI)
    ) u_decode (
        .addr  (req_addr),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // Only the slave latched at accept is ever looked at; the others are don't-care
    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign sel_rdata = PRDATA[{idx_q, 5'd0} +: 32];

    assign req_ready = (state_q == IDLE) && !PRESET;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

    // Next-state and registered-output computation; response fields default to a cleared pulse
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    pwrite_d = req_write;
                    idx_d    = dec_idx;
                    if (dec_legal) begin
                        psel_d  = NUM_SLV'(1) << dec_idx;
                        state_d = SETUP;
                    end else begin
                        state_d = DERR;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = 16'd0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : 32'd0;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any transfer in flight without a response
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            pwrite_q    <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with random and directed transfers
module tb_apb_master_bridge;

    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;

    logic                  PCLK = 1'b0;
    logic                  PRESET;
    logic                  req_valid;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [31:0]           PADDR;
    logic [NUM_SLV-1:0]    PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [32*NUM_SLV-1:0] PRDATA;
    logic [NUM_SLV-1:0]    PREADY;
    logic [NUM_SLV-1:0]    PSLVERR;

    apb_master_bridge #(
        .NUM_SLV (NUM_SLV),
        .BASE_HI (16'h0001),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          pen;
        logic [3:0]  psel;
        int          issue;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          hung = 0;
    int          cur_w = 0;
    logic        cur_err = 1'b0;
    logic [31:0] cur_data = 32'd0;
    int          acc_cnt;
    int          pen_cnt;
    logic [3:0]  psel_seen;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                                   input int w, input logic serr, input logic [31:0] data);
        exp_t e;
        int   n;
        int   idx;
        bit   legal;
        e.addr  = addr;
        e.wdata = wdata;
        e.write = wr;
        e.issue = 0;
        idx     = int'((addr >> 12) & 32'd3);
        legal   = ((addr >> 16) == 32'h0001) && (((addr >> 14) & 32'd3) == 0)
               && ((addr & 32'd3) == 0) && (idx < NUM_SLV);
        if (!legal) begin
            e.err = 1'b1; e.rdata = 32'd0; e.pen = 0; e.psel = 4'd0; e.lat = 2;
        end else begin
            n       = (w + 1 > TIMEOUT) ? TIMEOUT : w + 1;
            e.err   = (w + 1 > TIMEOUT) || serr;
            e.rdata = (!wr && !e.err) ? data : 32'd0;
            e.pen   = n;
            e.psel  = 4'(1 << idx);
            e.lat   = n + 2;
        end
        return e;
    endfunction

    // Present one request as soon as the bridge is ready; optionally record its expected response
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                         input int w, input logic serr, input logic [31:0] data, input bit track);
        int   guard;
        exp_t e;
        @(negedge PCLK);
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_wait: got 0 required 1 within 100 cycles");
            hung = 1;
            return;
        end
        cur_w     = w;
        cur_err   = serr;
        cur_data  = data;
        req_valid = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_write = wr;
        if (track) begin
            e = model(addr, wdata, wr, w, serr, data);
            e.issue = cyc;
            sb_q.push_back(e);
        end
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
    endtask

    // Slave side: selected slave answers after cur_w wait cycles, every other input is noise
    initial begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        acc_cnt = 0;
        forever begin
            @(negedge PCLK);
            PREADY  = 4'($urandom);
            PSLVERR = 4'($urandom);
            for (int i = 0; i < NUM_SLV; i++) PRDATA[i*32 +: 32] = $urandom;
            if (PRESET) begin
                acc_cnt = 0;
            end else if (PENABLE && PSEL != '0) begin
                acc_cnt++;
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (PSEL[i]) begin
                        PREADY[i]          = (acc_cnt == cur_w + 1);
                        PSLVERR[i]         = cur_err;
                        PRDATA[i*32 +: 32] = cur_data;
                    end
                end
            end else begin
                acc_cnt = 0;
            end
        end
    end

    // Monitor: accumulate per-transfer bus activity and compare on every response pulse
    initial begin
        exp_t e;
        pen_cnt   = 0;
        psel_seen = '0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                pen_cnt   = 0;
                psel_seen = '0;
            end else begin
                if (PENABLE) pen_cnt++;
                psel_seen = psel_seen | PSEL;
                if (rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("latency", 32'(cyc - e.issue), 32'(e.lat));
                        check("penable_cycles", 32'(pen_cnt), 32'(e.pen));
                        check("psel", 32'(psel_seen), 32'(e.psel));
                        check("paddr", PADDR, e.addr);
                        check("pwdata", PWDATA, e.wdata);
                        check("pwrite", 32'(PWRITE), 32'(e.write));
                    end
                    pen_cnt   = 0;
                    psel_seen = '0;
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_psel"}, 32'(PSEL), 32'd0);
        check({tag, "_penable"}, 32'(PENABLE), 32'd0);
        check({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
        check({tag, "_paddr"}, PADDR, 32'd0);
        check({tag, "_pwdata"}, PWDATA, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        int          w;
        int          guard;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge PCLK);
        check_zero_outputs("reset");
        PRESET = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Directed cases
        issue(32'h0001_1004, 32'hA5A5_0001, 1'b1, 0, 1'b0, $urandom, 1'b1);
        issue(32'h0001_2000, $urandom, 1'b0, 3, 1'b0, 32'h1234_5678, 1'b1);
        if (!hung) issue(32'h0002_0000, $urandom, 1'b0, 0, 1'b0, $urandom, 1'b1);
        if (!hung) issue(32'h0001_0002, $urandom, 1'b0, 0, 1'b0, $urandom, 1'b1);
        if (!hung) issue(32'h0001_0010, $urandom, 1'b0, 20, 1'b0, $urandom, 1'b1);
        if (!hung) issue(32'h0001_0014, $urandom, 1'b0, 15, 1'b0, 32'hCAFE_F00D, 1'b1);
        if (!hung) issue(32'h0001_3008, $urandom, 1'b0, 1, 1'b1, 32'hDEAD_BEEF, 1'b1);

        // Reset pulse during ACCESS aborts silently
        if (!hung) begin
            issue(32'h0001_3000, 32'h5555_AAAA, 1'b1, 10, 1'b0, $urandom, 1'b0);
            @(negedge PCLK);
            @(negedge PCLK);
            check("abort_in_access", 32'(PENABLE), 32'd1);
            #2;
            PRESET = 1'b1;
            #1;
            check_zero_outputs("abort");
            @(negedge PCLK);
            PRESET = 1'b0;
            #1;
            check("ready_after_abort", 32'(req_ready), 32'd1);
        end

        // Randomized traffic, back-to-back whenever the bridge allows
        for (int t = 0; t < 150 && !hung; t++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: addr = {16'h0001, 2'b00, 2'($urandom), 10'($urandom), 2'b00};
                4:          addr = {16'($urandom_range(0, 3)), 16'($urandom)};
                default:    addr = {16'h0001, 2'($urandom), 2'($urandom), 10'($urandom), 2'($urandom)};
            endcase
            w = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 18));
            issue(addr, $urandom, 1'($urandom), w, 1'($urandom_range(0, 3) == 0), $urandom, 1'b1);
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge PCLK);
            guard++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d outstanding responses required 0", sb_q.size());
        end
        repeat (2) @(negedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
